// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore-style multicycle MIPS control FSM; define MIPS_MC_ORI_EN to add ori support
module mips_multicycle_ctrl (
   input  logic       CLK,
   input  logic       Reset,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       Branch,
   output logic       PCEn,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemToReg,
   output logic       RegWrite,
   output logic       AluSrcA,
   output logic [1:0] AluSrcB,
   output logic [2:0] AluCtl,
   output logic [1:0] PCSource,
   output logic       ExtOp,
   output logic       Illegal,
   output logic [3:0] State
);
   localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                          MEMWB = 4'd4, MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7,
                          BRANCH = 4'd8, ADDIEX = 4'd9, IMMWB = 4'd10, JUMP = 4'd11,
                          ORIEX = 4'd12;
   localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                          OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010,
                          OP_ORI = 6'b001101;
   localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                          F_OR = 6'b100101, F_SLT = 6'b101010;

   logic [3:0] state, nextState, decodeNext;
   logic       isStore, functLegal;
   logic [2:0] rCtl;

   assign functLegal = Funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
   assign rCtl = (Funct == F_ADD) ? 3'b010 :
                 (Funct == F_SUB) ? 3'b110 :
                 (Funct == F_AND) ? 3'b000 :
                 (Funct == F_OR)  ? 3'b001 : 3'b111;
   assign PCEn  = PCWrite | (Branch & Zero);
   assign State = state;

   // state register; lw/sw choice is latched in DECODE so Op is not looked at again later
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state   <= FETCH;
         isStore <= 1'b0;
      end else begin
         state   <= nextState;
         if (state == DECODE) isStore <= (Op == OP_SW);
      end
   end

   // opcode dispatch out of DECODE; FETCH here means the instruction is unsupported
   always_comb begin
      decodeNext = FETCH;
      case (Op)
         OP_LW, OP_SW: decodeNext = MEMADR;
         OP_RTYPE:     decodeNext = functLegal ? EXEC : FETCH;
         OP_BEQ:       decodeNext = BRANCH;
         OP_ADDI:      decodeNext = ADDIEX;
         OP_J:         decodeNext = JUMP;
`ifdef MIPS_MC_ORI_EN
         OP_ORI:       decodeNext = ORIEX;
`endif
         default:      decodeNext = FETCH;
      endcase
   end

   // next-state sequencing with memory-ready stalls
   always_comb begin
      nextState = FETCH;
      case (state)
         FETCH:   nextState = MemReady ? DECODE : FETCH;
         DECODE:  nextState = decodeNext;
         MEMADR:  nextState = isStore ? MEMWR : MEMRD;
         MEMRD:   nextState = MemReady ? MEMWB : MEMRD;
         MEMWR:   nextState = MemReady ? FETCH : MEMWR;
         EXEC:    nextState = ALUWB;
         ADDIEX:  nextState = IMMWB;
`ifdef MIPS_MC_ORI_EN
         ORIEX:   nextState = IMMWB;
`endif
         default: nextState = FETCH;
      endcase
   end

   // per-state control outputs; FETCH strobes are masked so reset silences them at once
   always_comb begin
      PCWrite  = 1'b0;
      Branch   = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegDst   = 1'b0;
      MemToReg = 1'b0;
      RegWrite = 1'b0;
      AluSrcA  = 1'b0;
      AluSrcB  = 2'b00;
      AluCtl   = 3'b000;
      PCSource = 2'b00;
      ExtOp    = 1'b0;
      Illegal  = 1'b0;
      case (state)
         FETCH: begin
            MemRead = ~Reset;
            IRWrite = MemReady & ~Reset;
            PCWrite = MemReady & ~Reset;
            AluSrcB = 2'b01;
            AluCtl  = 3'b010;
         end
         DECODE: begin
            AluSrcB = 2'b11;
            AluCtl  = 3'b010;
            ExtOp   = 1'b1;
            Illegal = (decodeNext == FETCH);
         end
         MEMADR, ADDIEX: begin
            AluSrcA = 1'b1;
            AluSrcB = 2'b10;
            AluCtl  = 3'b010;
            ExtOp   = 1'b1;
         end
         MEMRD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
         end
         MEMWB: begin
            MemToReg = 1'b1;
            RegWrite = 1'b1;
         end
         MEMWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         EXEC: begin
            AluSrcA = 1'b1;
            AluCtl  = rCtl;
         end
         ALUWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
         end
         BRANCH: begin
            AluSrcA  = 1'b1;
            AluCtl   = 3'b110;
            PCSource = 2'b01;
            Branch   = 1'b1;
         end
         IMMWB: RegWrite = 1'b1;
         JUMP: begin
            PCSource = 2'b10;
            PCWrite  = 1'b1;
         end
`ifdef MIPS_MC_ORI_EN
         ORIEX: begin
            AluSrcA = 1'b1;
            AluSrcB = 2'b10;
            AluCtl  = 3'b001;
         end
`endif
         default: ;
      endcase
   end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: scoreboard bench for the multicycle MIPS control FSM
module tb_mips_multicycle_ctrl;
   typedef struct packed {
      logic pcWrite, branch, pcEn, iorD, memRead, memWrite, irWrite, regDst, memToReg, regWrite, aluSrcA;
      logic [1:0] aluSrcB;
      logic [2:0] aluCtl;
      logic [1:0] pcSource;
      logic extOp, illegal;
   } outs_t;
   typedef struct packed {
      logic mr, z;
      logic [3:0] st;
      outs_t o;
   } exp_t;

   logic CLK = 1'b0, Reset = 1'b1, Zero = 1'b0, MemReady = 1'b1;
   logic [5:0] Op = 6'd0, Funct = 6'd0;
   logic PCWrite, Branch, PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, AluSrcA, ExtOp, Illegal;
   logic [1:0] AluSrcB, PCSource;
   logic [2:0] AluCtl;
   logic [3:0] State;
   outs_t obs;
   exp_t q[$];
   int checks = 0, errors = 0;

   mips_multicycle_ctrl dut (
      .CLK(CLK), .Reset(Reset), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
      .PCWrite(PCWrite), .Branch(Branch), .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemToReg(MemToReg),
      .RegWrite(RegWrite), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluCtl(AluCtl),
      .PCSource(PCSource), .ExtOp(ExtOp), .Illegal(Illegal), .State(State)
   );

   always #5 CLK = ~CLK;

   function automatic exp_t mk(input logic [3:0] s, input logic mr, input logic z, input logic ill, input logic [2:0] ctl);
      exp_t e;
      e = '0;
      e.mr = mr;
      e.z = z;
      e.st = s;
      case (s)
         4'd0: begin e.o.memRead = 1; e.o.irWrite = mr; e.o.pcWrite = mr; e.o.pcEn = mr; e.o.aluSrcB = 2'b01; e.o.aluCtl = 3'b010; end
         4'd1: begin e.o.aluSrcB = 2'b11; e.o.aluCtl = 3'b010; e.o.extOp = 1; e.o.illegal = ill; end
         4'd2, 4'd9: begin e.o.aluSrcA = 1; e.o.aluSrcB = 2'b10; e.o.aluCtl = 3'b010; e.o.extOp = 1; end
         4'd3: begin e.o.iorD = 1; e.o.memRead = 1; end
         4'd4: begin e.o.memToReg = 1; e.o.regWrite = 1; end
         4'd5: begin e.o.iorD = 1; e.o.memWrite = 1; end
         4'd6: begin e.o.aluSrcA = 1; e.o.aluCtl = ctl; end
         4'd7: begin e.o.regDst = 1; e.o.regWrite = 1; end
         4'd8: begin e.o.aluSrcA = 1; e.o.aluCtl = 3'b110; e.o.pcSource = 2'b01; e.o.branch = 1; e.o.pcEn = z; end
         4'd10: e.o.regWrite = 1;
         4'd11: begin e.o.pcSource = 2'b10; e.o.pcWrite = 1; e.o.pcEn = 1; end
         4'd12: begin e.o.aluSrcA = 1; e.o.aluSrcB = 2'b10; e.o.aluCtl = 3'b001; end
         default: ;
      endcase
      return e;
   endfunction

   task automatic push(input logic [3:0] s, input logic mr = 1'b1, input logic z = 1'b0, input logic ill = 1'b0, input logic [2:0] ctl = 3'b000);
      q.push_back(mk(s, mr, z, ill, ctl));
   endtask

   task automatic drain(input string tag);
      int n;
      exp_t e;
      n = 0;
      while (q.size() > 0) begin
         e = q.pop_front();
         MemReady = e.mr;
         Zero = e.z;
         @(negedge CLK);
         obs = {PCWrite, Branch, PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
                AluSrcA, AluSrcB, AluCtl, PCSource, ExtOp, Illegal};
         checks++;
         if (State !== e.st || obs !== e.o) begin
            errors++;
            $display("FAIL %s cycle %0d: got state %0d outputs %h, expected state %0d outputs %h", tag, n, State, obs, e.st, e.o);
         end
         @(posedge CLK);
         #1;
         n++;
      end
   endtask

   task automatic test_reset;
      exp_t e;
      #1;
      checks++;
      if (State !== 4'd0) begin
         errors++;
         $display("FAIL reset_async: got state %0d, expected 0", State);
      end
      e = mk(4'd0, 1'b1, 1'b0, 1'b0, 3'b000);
      e.o.memRead = 0;
      e.o.irWrite = 0;
      e.o.pcWrite = 0;
      e.o.pcEn = 0;
      repeat (3) q.push_back(e);
      @(posedge CLK);
      #1;
      drain("reset_held");
      Reset = 1'b0;
   endtask

   task automatic test_lw;
      Op = 6'b100011;
      push(0); push(1); push(2); push(3); push(4); push(0, 0);
      drain("lw");
      push(0); push(1); push(2); push(3, 0); push(3); push(4); push(0, 0);
      drain("lw_stall");
   endtask

   task automatic test_sw;
      Op = 6'b101011;
      push(0); push(1); push(2); push(5, 0); push(5, 0); push(5); push(0, 0);
      drain("sw_stall");
   endtask

   task automatic test_beq;
      Op = 6'b000100;
      push(0, 1, 1); push(1, 1, 1); push(8, 1, 1); push(0, 0);
      drain("beq_taken");
      push(0); push(1); push(8, 1, 0); push(0, 0, 1);
      drain("beq_not_taken");
   endtask

   task automatic test_rtype;
      logic [5:0] fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      logic [2:0] ct [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
      Op = 6'b000000;
      for (int i = 0; i < 5; i++) begin
         Funct = fn[i];
         push(0); push(1); push(6, 1, 0, 0, ct[i]); push(7); push(0, 0);
         drain("rtype");
      end
      Funct = 6'b000111;
      push(0); push(1, 1, 0, 1); push(0, 0);
      drain("rtype_illegal_funct");
   endtask

   task automatic test_imm_jump;
      Op = 6'b001000;
      push(0); push(1); push(9); push(10); push(0, 0);
      drain("addi");
      Op = 6'b000010;
      push(0); push(1); push(11); push(0, 0);
      drain("j");
      Op = 6'b001101;
`ifdef MIPS_MC_ORI_EN
      push(0); push(1); push(12); push(10); push(0, 0);
`else
      push(0); push(1, 1, 0, 1); push(0, 0);
`endif
      drain("ori");
      Op = 6'b111111;
      push(0); push(1, 1, 0, 1); push(0, 0);
      drain("illegal_op");
   endtask

   task automatic test_abort;
      Op = 6'b100011;
      push(0); push(1); push(2);
      drain("abort_setup");
      MemReady = 1'b0;
      @(negedge CLK);
      checks++;
      if ({State, MemRead, IorD} !== {4'd3, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL abort_before: got state %0d memread %b iord %b, expected 3 1 1", State, MemRead, IorD);
      end
      #1 Reset = 1'b1;
      #1;
      checks++;
      if ({State, MemRead, IorD, IRWrite, PCWrite, PCEn, RegWrite, AluSrcB} !== {4'd0, 6'b000000, 2'b01}) begin
         errors++;
         $display("FAIL abort_reset: got state %0d mr %b iord %b ir %b pcw %b pcen %b rw %b srcb %b, expected 0 0 0 0 0 0 0 01",
                  State, MemRead, IorD, IRWrite, PCWrite, PCEn, RegWrite, AluSrcB);
      end
      @(posedge CLK);
      #1 Reset = 1'b0;
      push(0); push(1); push(2); push(3); push(4); push(0, 0);
      drain("after_abort");
   endtask

   initial begin
      test_reset;
      test_lw;
      test_sw;
      test_beq;
      test_rtype;
      test_imm_jump;
      test_abort;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Moore-style multicycle control FSM for the MIPS datapath. It sequences fetch, decode, execute, memory and writeback over several cycles through one shared ALU and one shared instruction/data memory port. It sits beside the multicycle `datapath` in place of the single-cycle `controller`, decodes opcode/funct from the datapath's instruction register, and stalls on a memory-ready handshake.

## Interface
- No parameters.
- `CLK` input 1: sole clock, rising edge.
- `Reset` input 1: asynchronous, active-high; forces state to FETCH.
- `Op` input 6: Instr[31:26] from IR.
- `Funct` input 6: Instr[5:0] from IR.
- `Zero` input 1: ALU zero flag.
- `MemReady` input 1: memory completes the current access this cycle.
- `PCWrite` / `Branch` / `PCEn` output 1 each: unconditional PC write, conditional branch, and the PC enable. `PCEn = PCWrite | (Branch & Zero)`.
- `IorD` output 1: memory address select (0 = PC, 1 = ALUOut).
- `MemRead` / `MemWrite` / `IRWrite` output 1 each: memory strobes and IR load.
- `RegDst` / `MemToReg` / `RegWrite` output 1 each: register file write controls.
- `AluSrcA` output 1: selects 0 = PC or 1 = A.
- `AluSrcB` output 2: selects 00 = B, 01 = 4, 10 = ext imm, 11 = ext imm<<2.
- `AluCtl` output 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `PCSource` output 2: selects 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ExtOp` output 1: 1 = sign-extend, 0 = zero-extend.
- `Illegal` output 1: one-cycle pulse on an unsupported instruction.
- `State` output 4: current state, for debug.

## Operation
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, IMMWB 10, JUMP 11, ORIEX 12. Codes 13–15 are unreachable and return to FETCH.
- Any output not listed for a state is 0.
- FETCH:
  - Outputs: MemRead=1, IorD=0, AluSrcA=0, AluSrcB=01, AluCtl=010, PCSource=00.
  - IRWrite=PCWrite=MemReady. These two outputs are Mealy on MemReady.
  - Stays in FETCH while MemReady=0, otherwise goes to DECODE.
- DECODE:
  - Outputs: AluSrcA=0, AluSrcB=11, AluCtl=010, ExtOp=1.
  - Next state by Op: 100011 or 101011 → MEMADR; 000000 → EXEC; 000100 → BRANCH; 001000 → ADDIEX; 000010 → JUMP; 001101 → ORIEX (only with the macro).
  - Any other Op, or R-type with Funct not in {100000, 100010, 100100, 100101, 101010}: Illegal=1 for this cycle, then FETCH. No architectural write occurs.
- MEMADR:
  - Outputs: AluSrcA=1, AluSrcB=10, AluCtl=010, ExtOp=1.
  - Next state: MEMRD for lw, MEMWR for sw.
- MEMRD:
  - Outputs: IorD=1, MemRead=1.
  - Holds until MemReady=1, then goes to MEMWB.
- MEMWB:
  - Outputs: RegDst=0, MemToReg=1, RegWrite=1.
  - Next state: FETCH.
- MEMWR:
  - Outputs: IorD=1, MemWrite=1.
  - Holds until MemReady=1, then goes to FETCH.
- EXEC:
  - Outputs: AluSrcA=1, AluSrcB=00.
  - AluCtl from Funct: add 010, sub 110, and 000, or 001, slt 111.
  - Next state: ALUWB.
- ALUWB:
  - Outputs: RegDst=1, MemToReg=0, RegWrite=1.
  - Next state: FETCH.
- BRANCH:
  - Outputs: AluSrcA=1, AluSrcB=00, AluCtl=110, PCSource=01, Branch=1.
  - Next state: FETCH.
- ADDIEX:
  - Outputs: AluSrcA=1, AluSrcB=10, AluCtl=010, ExtOp=1.
  - Next state: IMMWB.
- IMMWB:
  - Outputs: RegDst=0, MemToReg=0, RegWrite=1.
  - Next state: FETCH.
- JUMP:
  - Outputs: PCSource=10, PCWrite=1.
  - Next state: FETCH.
- ORIEX:
  - Outputs: AluSrcA=1, AluSrcB=10, AluCtl=001, ExtOp=0.
  - Next state: IMMWB.

## Timing
- Reset asserted:
  - State=0 immediately, without waiting for a clock edge.
  - All strobes are 0: PCWrite, IRWrite, PCEn, Branch, MemRead, MemWrite, RegWrite, Illegal.
  - Mux selects take their FETCH values.
  - First fetch begins on the first rising edge after Reset deasserts.
- Latency with MemReady tied to 1:
  - lw: 5 cycles.
  - sw, R-type, addi, ori: 4 cycles.
  - beq, j: 3 cycles.
  - illegal instruction: 2 cycles.
- Memory handshake:
  - Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
  - The strobe stays held and the address select stays stable throughout the wait.
- Op and Funct are sampled only in DECODE and EXEC. IR is stable there because IRWrite=0 outside FETCH.
- PCEn is combinational on Zero during BRANCH.
- Reset asserted mid-instruction aborts the instruction. Any strobe active that cycle drops within the same cycle.

## Configuration
- Macro: `MIPS_MC_ORI_EN`.
- Defined: Op 001101 goes DECODE→ORIEX→IMMWB→FETCH, with zero-extended immediate and OR.
- Undefined: ORIEX logic is absent. Op 001101 is illegal (Illegal pulse in DECODE, then FETCH). State code 12 is unreachable and falls to FETCH.

## Test plan
- Reset held 3 cycles, then released, MemReady=1 → State=0 with all strobes 0 during reset; IRWrite=1 and PCWrite=1 on the first clock cycle after release.
- lw (Op 100011), MemReady=1 → states 0,1,2,3,4,0; RegWrite=1 with MemToReg=1 only in state 4.
- sw (Op 101011) with MemReady=0 for 2 cycles in MEMWR → MemWrite held high for 3 cycles, IorD=1, then FETCH.
- beq (Op 000100) with Zero=1, then again with Zero=0 → PCEn=1 in BRANCH for the first, PCEn=0 for the second; AluCtl=110 in both.
- R-type slt (Funct 101010) → AluCtl=111 in EXEC; RegDst=1 and RegWrite=1 in ALUWB. Funct 000111 → Illegal=1 in DECODE, next state FETCH, RegWrite never asserted.
- ori (Op 001101) → with `MIPS_MC_ORI_EN`: states 0,1,12,10, ExtOp=0, AluCtl=001. Without the macro: Illegal=1, then FETCH.
